// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock AXI4-Stream FIFO with a first-word-fall-through head.
// Define AXIS_FIFO_STATUS_EN to expose the occupancy register on status_count.
module axis_sync_fifo #(
    parameter int DEPTH       = 4096,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 1,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
`ifdef AXIS_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] status_count
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    // Stored word layout, LSB first: tdata, then whichever sidebands are enabled.
    localparam int W_K    = DATA_WIDTH + ((KEEP_ENABLE != 0) ? KEEP_WIDTH : 0);
    localparam int W_L    = W_K + ((LAST_ENABLE != 0) ? 1 : 0);
    localparam int WORD_W = W_L + ((USER_ENABLE != 0) ? USER_WIDTH : 0);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              rstn_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [W_K-1:0]    word_k;
    logic [W_L-1:0]    word_l;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign full          = (count == CNT_FULL);
    assign empty         = (count == '0);
    assign s_axis_tready = !full && rstn_q;
    assign m_axis_tvalid = !empty;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;

    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            assign word_k       = {s_axis_tkeep, s_axis_tdata};
            assign m_axis_tkeep = rd_word[W_K-1 -: KEEP_WIDTH];
        end else begin : g_no_keep
            logic unused_keep;
            assign unused_keep  = ^s_axis_tkeep;
            assign word_k       = s_axis_tdata;
            assign m_axis_tkeep = '1;
        end

        if (LAST_ENABLE != 0) begin : g_last
            assign word_l       = {s_axis_tlast, word_k};
            assign m_axis_tlast = rd_word[W_L-1];
        end else begin : g_no_last
            logic unused_last;
            assign unused_last  = s_axis_tlast;
            assign word_l       = word_k;
            assign m_axis_tlast = 1'b1;
        end

        if (USER_ENABLE != 0) begin : g_user
            assign wr_word      = {s_axis_tuser, word_l};
            assign m_axis_tuser = rd_word[WORD_W-1 -: USER_WIDTH];
        end else begin : g_no_user
            logic unused_user;
            assign unused_user  = ^s_axis_tuser;
            assign wr_word      = word_l;
            assign m_axis_tuser = '0;
        end
    endgenerate

    assign rd_word      = mem[rd_ptr];
    assign m_axis_tdata = rd_word[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstn_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rstn_q <= 1'b1;
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage is not reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

`ifdef AXIS_FIFO_STATUS_EN
    assign status_count = count;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb_axis_sync_fifo: scoreboard bench for a 1024x32 FIFO plus a 64-bit instance
// with tlast/tuser disabled and tkeep stored.
module tb_axis_sync_fifo;

    logic        clk = 1'b0;
    logic        rstn;

    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready;

    logic [63:0] x_s_tdata;
    logic [7:0]  x_s_tkeep;
    logic        x_s_tlast;
    logic [0:0]  x_s_tuser;
    logic        x_s_tvalid;
    logic        x_s_tready;
    logic [63:0] x_m_tdata;
    logic [7:0]  x_m_tkeep;
    logic        x_m_tlast;
    logic [0:0]  x_m_tuser;
    logic        x_m_tvalid;
    logic        x_m_tready;

`ifdef AXIS_FIFO_STATUS_EN
    logic [10:0] status_count;
    logic [2:0]  x_status_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [37:0] sb[$];

    always #5 clk = ~clk;

    axis_sync_fifo #(
        .DEPTH(1024), .DATA_WIDTH(32)
    ) u_dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
`ifdef AXIS_FIFO_STATUS_EN
        , .status_count(status_count)
`endif
    );

    axis_sync_fifo #(
        .DEPTH(4), .DATA_WIDTH(64), .KEEP_ENABLE(1), .LAST_ENABLE(0), .USER_ENABLE(0)
    ) u_side (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(x_s_tdata), .s_axis_tkeep(x_s_tkeep), .s_axis_tlast(x_s_tlast),
        .s_axis_tuser(x_s_tuser), .s_axis_tvalid(x_s_tvalid), .s_axis_tready(x_s_tready),
        .m_axis_tdata(x_m_tdata), .m_axis_tkeep(x_m_tkeep), .m_axis_tlast(x_m_tlast),
        .m_axis_tuser(x_m_tuser), .m_axis_tvalid(x_m_tvalid), .m_axis_tready(x_m_tready)
`ifdef AXIS_FIFO_STATUS_EN
        , .status_count(x_status_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d);
        s_tdata = d;
        s_tkeep = d[3:0];
        s_tlast = d[4];
        s_tuser = d[5];
    endtask

    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (m_tvalid === 1'b1 && n < exp_n + 50) begin
            n++;
            tick();
        end
        m_tready = 1'b0;
        check(tag, 64'(n), 64'(exp_n));
        check({tag, "_empty"}, 64'(m_tvalid), 64'd0);
    endtask

    // Scoreboard: record beats at the input handshake, compare at the output handshake.
    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            sb.delete();
        end else begin
`ifdef AXIS_FIFO_STATUS_EN
            check("status_count", 64'(status_count), 64'(sb.size()));
`endif
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("sb_beat", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'(sb.pop_front()));
                end
            end
            if (s_tvalid === 1'b1 && s_tready === 1'b1) begin
                sb.push_back({s_tdata, s_tkeep, s_tlast, s_tuser});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cycles;
        rstn       = 1'b0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b0;
        drive(32'h0);
        x_s_tvalid = 1'b0;
        x_m_tready = 1'b0;
        x_s_tdata  = '0;
        x_s_tkeep  = '0;
        x_s_tlast  = 1'b0;
        x_s_tuser  = '0;
        tick();
        tick();
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        rstn = 1'b1;
        check("rel_tready_pre", 64'(s_tready), 64'd0);
        tick();
        check("rel_tready", 64'(s_tready), 64'd1);

        // Fill to capacity with the allocator's address pattern.
        check("fill_tvalid0", 64'(m_tvalid), 64'd0);
        idx = 0;
        cycles = 0;
        s_tvalid = 1'b1;
        drive(32'h1c10_0000);
        while (idx < 1024 && cycles < 1100) begin
            if (s_tready) idx++;
            tick();
            cycles++;
            if (cycles == 1) check("fill_tvalid1", 64'(m_tvalid), 64'd1);
            drive(32'h1c10_0000 + 32'(1536 * idx));
        end
        check("fill_cycles", 64'(cycles), 64'd1024);
        check("full_tready", 64'(s_tready), 64'd0);
        tick();
        tick();
        check("full_hold", 64'(s_tready), 64'd0);
        check("head_hold", 64'(m_tdata), 64'h1c10_0000);

        // Single pop at T from full: no write-through, ready at T+1.
        drive(32'hDEAD_0001);
        m_tready = 1'b1;
        check("pop_T_tready", 64'(s_tready), 64'd0);
        tick();
        m_tready = 1'b0;
        check("pop_T1_tready", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
        check("refull_tready", 64'(s_tready), 64'd0);
        drain("drain_full", 1024);

        // Half full, then sustained push and pop.
        s_tvalid = 1'b1;
        idx = 0;
        cycles = 0;
        while (idx < 512 && cycles < 600) begin
            drive(32'h3000_0000 + 32'(idx * 7));
            if (s_tready) idx++;
            tick();
            cycles++;
        end
        m_tready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            drive(32'h4000_0000 + 32'(c * 13));
            check("steady", 64'({s_tready, m_tvalid}), 64'd3);
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        drain("drain_half", 512);

        // Reset pulse while holding 10 beats.
        s_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(32'h5000_0000 + 32'(k));
            tick();
        end
        s_tvalid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_tready", 64'(s_tready), 64'd0);
        tick();
        check("mid_rel_tready", 64'(s_tready), 64'd1);
        drive(32'hA5A5_A5A5);
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check("mid_first", 64'(m_tdata), 64'hA5A5_A5A5);
        drain("drain_rst", 1);

        // Disabled tlast/tuser, stored tkeep.
        x_s_tvalid = 1'b1;
        x_s_tdata  = 64'h0123_4567_89AB_CDEF;
        x_s_tkeep  = 8'h0F;
        x_s_tlast  = 1'b0;
        x_s_tuser  = 1'b1;
        tick();
        x_s_tdata  = 64'hFEDC_BA98_7654_3210;
        x_s_tkeep  = 8'hF0;
        x_s_tlast  = 1'b1;
        x_s_tuser  = 1'b0;
        tick();
        x_s_tvalid = 1'b0;
        check("x_tvalid", 64'(x_m_tvalid), 64'd1);
        check("x_data0", x_m_tdata, 64'h0123_4567_89AB_CDEF);
        check("x_keep0", 64'(x_m_tkeep), 64'h0F);
        check("x_last0", 64'(x_m_tlast), 64'd1);
        check("x_user0", 64'(x_m_tuser), 64'd0);
        x_m_tready = 1'b1;
        tick();
        x_m_tready = 1'b0;
        check("x_data1", x_m_tdata, 64'hFEDC_BA98_7654_3210);
        check("x_keep1", 64'(x_m_tkeep), 64'hF0);
        check("x_last1", 64'(x_m_tlast), 64'd1);
        check("x_user1", 64'(x_m_tuser), 64'd0);

        tick();
        check("sb_left", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Single-clock AXI4-Stream FIFO with parameterised depth, data width and optional TKEEP/TLAST/TUSER sidebands. The packet allocator uses it as free-address pools, e.g. 1024 or 8192 entries of 32-bit buffer addresses. The allocator fills it to exact capacity at start-up, pops on packet arrival and pushes on feedback. Stored beats come out in first-in-first-out order with no loss.

## Interface
- DEPTH, 4096: capacity in beats; any value ≥ 2; exactly DEPTH beats storable.
- DATA_WIDTH, 8: tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8): store tkeep.
- KEEP_WIDTH, (DATA_WIDTH+7)/8: tkeep width.
- LAST_ENABLE, 1: store tlast.
- USER_ENABLE, 1: store tuser.
- USER_WIDTH, 1: tuser width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  write data.
- s_axis_tkeep  in  KEEP_WIDTH  ignored when KEEP_ENABLE=0.
- s_axis_tlast  in  1  ignored when LAST_ENABLE=0.
- s_axis_tuser  in  USER_WIDTH  ignored when USER_ENABLE=0.
- s_axis_tvalid  in  1  write request.
- s_axis_tready  out  1  high when not full and not in reset.
- m_axis_tdata  out  DATA_WIDTH  head beat data.
- m_axis_tkeep  out  KEEP_WIDTH  head tkeep; all ones when disabled.
- m_axis_tlast  out  1  head tlast; constant 1 when disabled.
- m_axis_tuser  out  USER_WIDTH  head tuser; zero when disabled.
- m_axis_tvalid  out  1  high when not empty.
- m_axis_tready  in  1  read acknowledge.
- status_count  out  $clog2(DEPTH+1)  occupancy; present only with AXIS_FIFO_STATUS_EN.

## Operation
- Storage: DEPTH-entry array of {tdata, enabled sidebands}. Write pointer, read pointer and occupancy count are registers.
- Push: when s_axis_tvalid && s_axis_tready at an edge, the beat is written at the write pointer and the pointer advances.
- Pop: when m_axis_tvalid && m_axis_tready at an edge, the read pointer advances.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0, including when DEPTH is not a power of two.
- Readiness flags: full is count==DEPTH and empty is count==0. s_axis_tready = !full && rstn_q, where rstn_q is a register that is 0 during reset. m_axis_tvalid = !empty.
- s_axis_tready never depends on m_axis_tready. There is no write-through when full, even if a pop happens in the same cycle.
- Simultaneous push and pop when neither full nor empty: both take effect and count is unchanged.
- Push while empty: the beat does not bypass to the output in the same cycle.
- Head outputs: m_axis_* always present the entry at the read pointer, first-word-fall-through. They hold stable while m_axis_tvalid is high and m_axis_tready is low.
- Disabled sidebands are not stored.

## Timing
- Reset: rstn low at an edge clears the pointers and count.
  - Outputs during reset and the cycle after it: m_axis_tvalid=0, s_axis_tready=0 (the latter driven low while rstn is low).
  - s_axis_tready rises in the first cycle after the edge at which rstn is sampled high.
  - Stored data is discarded and is don't-care.
  - Reset asserted mid-operation has the same effect: contents are lost and no beat is emitted afterwards.
- Write-to-read latency: a beat accepted at edge N makes m_axis_tvalid high after edge N, i.e. it is poppable at edge N+1.
- Flag update: full deasserts in the cycle after a pop from full, so s_axis_tready rises one cycle after that pop. Empty behaves symmetrically.
- Throughput: one push and one pop per cycle sustained.
- Output logic: all outputs are combinational from registers only; there are no combinational input-to-output paths.

## Configuration
- AXIS_FIFO_STATUS_EN defined: the status_count port exists and equals the occupancy register. It updates on the same edge as the pointers and is 0 in reset.
- Undefined: the port is absent. Internal count logic stays, since it drives full/empty.

## Test plan
- Reset release, DEPTH=1024, DATA_WIDTH=32, m_axis_tready=0: push 0x1c100000+1536*i for i=0..1023 back-to-back.
  - s_axis_tready is high for exactly 1024 accepts, then low.
  - m_axis_tvalid is high from the cycle after the first accept.
- From full: pop 1024 beats with m_axis_tready=1 throughout. Data equals the pushed sequence in order; m_axis_tvalid is low after the last pop.
- Half-full, continuous push and pop for 100 cycles: count stays constant and the output order matches the input.
- Full FIFO with s_axis_tvalid=1 and a single pop at cycle T: no push is accepted at T. s_axis_tready goes high at T+1 and one push is accepted there.
- rstn pulsed low for one cycle while 10 beats are stored:
  - m_axis_tvalid is 0 after the reset edge.
  - The next pushed value 0xA5A5A5A5 is the first beat popped.
- LAST_ENABLE=0, USER_ENABLE=0, DATA_WIDTH=64: m_axis_tlast=1 and m_axis_tuser=0 for any input. With KEEP_ENABLE=1, the stored value s_axis_tkeep=0x0F reappears as 0x0F.
